// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing the register file write port between
// the ALU (requester 0) and the load/store unit (requester 1).
module regfile_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [4:0]      req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [4:0]      req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  input  logic            wb_hold,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data,
  output logic            reg_write,
  output logic [31:0]     busy_mask,
  output logic            last_grant
);

  logic            grant0;
  logic            grant1;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            prio_q, prio_d;
  logic            last_grant_q, last_grant_d;
  logic            reg_write_q, reg_write_d;
  logic [4:0]      write_reg_q, write_reg_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [31:0]     busy_mask_q, busy_mask_d;

  // Arbitration: a lone valid wins outright, a tie goes to prio_q.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && !wb_hold) begin
      if (req0_valid && req1_valid) begin
        grant0 = !prio_q;
        grant1 = prio_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign sel_rd     = grant1 ? req1_rd : req0_rd;
  assign sel_data   = grant1 ? req1_data : req0_data;

  // Output stage drains every cycle; x0 writes consume the grant but load idle.
  always_comb begin
    prio_d       = prio_q;
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    write_reg_d  = 5'd0;
    write_data_d = '0;
    busy_mask_d  = 32'd0;
    if (grant0 || grant1) begin
      prio_d       = grant0;
      last_grant_d = grant1;
      if (sel_rd != 5'd0) begin
        reg_write_d  = 1'b1;
        write_reg_d  = sel_rd;
        write_data_d = sel_data;
        busy_mask_d  = 32'd1 << sel_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q       <= 1'b0;
      last_grant_q <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= '0;
      busy_mask_q  <= 32'd0;
    end else begin
      prio_q       <= prio_d;
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_mask_q  <= busy_mask_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign busy_mask  = busy_mask_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic against a behavioural arbiter/regfile model.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            wb_hold;
  logic            v0, v1;
  logic [4:0]      rd0, rd1;
  logic [XLEN-1:0] d0, d1;
  logic            ready0, ready1;
  logic [4:0]      write_reg;
  logic [XLEN-1:0] write_data;
  logic            reg_write;
  logic [31:0]     busy_mask;
  logic            last_grant;

  regfile_wb_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_rd(rd0), .req0_data(d0), .req0_ready(ready0),
    .req1_valid(v1), .req1_rd(rd1), .req1_data(d1), .req1_ready(ready1),
    .wb_hold(wb_hold),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .busy_mask(busy_mask), .last_grant(last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit              m_valid = 0;
  bit              m_prio, m_last, m_rw;
  logic [4:0]      m_wr;
  logic [XLEN-1:0] m_wd;
  logic [31:0]     m_busy;
  bit              mg0, mg1;
  logic [XLEN-1:0] rf [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare DUT against model, cross the edge, advance model.
  task automatic tick();
    bit              c_rw;
    logic [4:0]      c_wr;
    logic [XLEN-1:0] c_wd;
    logic [4:0]      rd;
    logic [XLEN-1:0] dat;
    #2;
    mg0 = 0;
    mg1 = 0;
    if (!reset && !wb_hold) begin
      if (v0 && v1) begin
        if (m_prio) mg1 = 1; else mg0 = 1;
      end else if (v0) mg0 = 1;
      else if (v1) mg1 = 1;
    end
    if (m_valid) begin
      chk("req0_ready", ready0, mg0);
      chk("req1_ready", ready1, mg1);
      chk("reg_write", reg_write, m_rw);
      chk("write_reg", write_reg, m_wr);
      chk("write_data", write_data, m_wd);
      chk("busy_mask", busy_mask, m_busy);
      chk("last_grant", last_grant, m_last);
    end
    c_rw = reg_write;
    c_wr = write_reg;
    c_wd = write_data;
    @(posedge clk);
    #1;
    if (m_valid && c_rw === 1'b1) rf[c_wr] = c_wd;
    if (reset) begin
      m_valid = 1;
      m_prio = 0; m_last = 0; m_rw = 0; m_wr = 0; m_wd = 0; m_busy = 0;
    end else if (mg0 || mg1) begin
      m_prio = mg0;
      m_last = mg1;
      rd  = mg1 ? rd1 : rd0;
      dat = mg1 ? d1 : d0;
      if (rd != 0) begin
        m_rw = 1; m_wr = rd; m_wd = dat; m_busy = 32'd1 << rd;
      end else begin
        m_rw = 0; m_wr = 0; m_wd = 0; m_busy = 0;
      end
    end else begin
      m_rw = 0; m_wr = 0; m_wd = 0; m_busy = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1; wb_hold = 0; v0 = 0; v1 = 0; rd0 = 0; rd1 = 0; d0 = 0; d1 = 0;
    #1;
    tick(); tick();
    reset = 0;
    chk("rst reg_write", reg_write, 0);
    chk("rst write_reg", write_reg, 0);
    chk("rst write_data", write_data, 0);
    chk("rst busy_mask", busy_mask, 0);
    chk("rst last_grant", last_grant, 0);

    // Single ALU write
    v0 = 1; rd0 = 5'd1; d0 = 32'haaaabbbb;
    #1;
    chk("single ready0", ready0, 1);
    tick();
    v0 = 0;
    chk("single reg_write", reg_write, 1);
    chk("single write_reg", write_reg, 1);
    chk("single write_data", write_data, 32'haaaabbbb);
    chk("single busy_mask", busy_mask, 32'h00000002);
    tick();
    chk("single rf x1", rf[1], 32'haaaabbbb);

    // Simultaneous after reset: req0 wins first
    reset = 1; tick(); reset = 0;
    v0 = 1; rd0 = 5'd2; d0 = 32'h11111111;
    v1 = 1; rd1 = 5'd3; d1 = 32'h22222222;
    #1;
    chk("dual ready0", ready0, 1);
    chk("dual ready1", ready1, 0);
    tick();
    v0 = 0;
    chk("dual last0", last_grant, 0);
    chk("dual wr2", write_reg, 2);
    #1;
    chk("dual ready1 next", ready1, 1);
    tick();
    v1 = 0;
    chk("dual last1", last_grant, 1);
    chk("dual wr3", write_reg, 3);
    tick(); tick();
    chk("dual rf x2", rf[2], 32'h11111111);
    chk("dual rf x3", rf[3], 32'h22222222);

    // Fairness: continuous dual requests alternate 0,1,0,1,0,1
    v0 = 1; rd0 = 5'd10; d0 = 32'h0a0a0000;
    v1 = 1; rd1 = 5'd20; d1 = 32'h14140000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fair last_grant", last_grant, i % 2);
      chk("fair reg_write", reg_write, 1);
      if (i % 2 == 0) begin rd0 = rd0 + 1; d0 = d0 + 1; end
      else begin rd1 = rd1 + 1; d1 = d1 + 1; end
    end
    v0 = 0; v1 = 0;

    // x0 write from LSU after an ALU grant (prio goes 1 then back to 0)
    v0 = 1; rd0 = 5'd7; d0 = 32'h77777777;
    tick();
    v0 = 0;
    v1 = 1; rd1 = 5'd0; d1 = 32'hffffffff;
    #1;
    chk("x0 ready1", ready1, 1);
    tick();
    v1 = 0;
    chk("x0 reg_write", reg_write, 0);
    chk("x0 busy_mask", busy_mask, 0);
    chk("x0 last_grant", last_grant, 1);
    v0 = 1; rd0 = 5'd8; d0 = 32'h88888888;
    v1 = 1; rd1 = 5'd9; d1 = 32'h99999999;
    #1;
    chk("x0 prio back to 0", ready0, 1);
    tick();
    v0 = 0;
    tick();
    v1 = 0;
    tick();
    chk("x0 rf x0", rf[0], 0);

    // Hold blocks acceptance for 3 cycles
    wb_hold = 1; v0 = 1; rd0 = 5'd5; d0 = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold ready0", ready0, 0);
      tick();
      chk("hold reg_write", reg_write, 0);
    end
    wb_hold = 0;
    #1;
    chk("release ready0", ready0, 1);
    tick();
    v0 = 0;
    chk("release reg_write", reg_write, 1);
    chk("release write_reg", write_reg, 5);
    tick();
    chk("release rf x5", rf[5], 32'h55555555);

    // Reset mid-stream
    v0 = 1; rd0 = 5'd4; d0 = 32'h44444444;
    tick();
    v0 = 0;
    chk("mid accepted", reg_write, 1);
    reset = 1;
    v0 = 1; v1 = 1; rd1 = 5'd6; d1 = 32'h66666666;
    #1;
    chk("mid rst ready0", ready0, 0);
    chk("mid rst ready1", ready1, 0);
    tick();
    chk("mid rst reg_write", reg_write, 0);
    chk("mid rst busy_mask", busy_mask, 0);
    chk("mid rst write_data", write_data, 0);
    reset = 0;
    #1;
    chk("mid prio 0", ready0, 1);
    tick();
    v0 = 0;
    tick();
    v1 = 0;
    tick();

    // Randomized traffic; requesters hold their request until granted
    for (int n = 0; n < 3000; n++) begin
      if (!v0 && ($urandom % 3) != 0) begin
        v0 = 1; rd0 = 5'($urandom); d0 = $urandom;
      end
      if (!v1 && ($urandom % 3) != 0) begin
        v1 = 1; rd1 = 5'($urandom); d1 = $urandom;
      end
      wb_hold = (($urandom % 8) == 0);
      reset = (n < 2990) && (($urandom % 60) == 0);
      tick();
      if (mg0) v0 = 0;
      if (mg1) v1 = 0;
    end
    v0 = 0; v1 = 0; wb_hold = 0; reset = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
